// File: rtl/alu_pkg.sv
// Shared widths, operation encoding and operand/result types for the FIR-datapath ALU.
package alu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned RES_W  = 32;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_SUB = 2'b10,
    OP_MAC = 2'b11
  } op_e;

  typedef logic signed [DATA_W-1:0] operand_t;
  typedef logic signed [RES_W-1:0]  result_t;

endpackage

// File: rtl/alu_mult.sv
// Combinational signed W x W -> 2W multiplier, kept separate so a pipelined or
// DSP-mapped implementation can be dropped in later.
module alu_mult
  import alu_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic signed [2*W-1:0] product
);

  localparam int unsigned PW = 2 * W;

  // Sign-extend before multiplying so the full-width product is exact.
  assign product = PW'(a) * PW'(b);

endmodule

// File: rtl/alu.sv
// Two-stage signed ALU: add, multiply, subtract and (with ALU_MAC_EN defined)
// multiply-accumulate into a wrapping accumulator. Without ALU_MAC_EN, op 11 yields 0.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = alu_pkg::DATA_W,
  parameter int unsigned RES_W  = alu_pkg::RES_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               op_sel,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [RES_W-1:0]  result
);

  if (RES_W < 2 * DATA_W) begin : g_width_check
    $error("alu: RES_W must be at least 2*DATA_W");
  end

  logic signed [DATA_W-1:0]   a_q;
  logic signed [DATA_W-1:0]   b_q;
  op_e                        op_q;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [RES_W-1:0]    a_ext;
  logic signed [RES_W-1:0]    b_ext;
  logic signed [RES_W-1:0]    prod_ext;
  logic signed [RES_W-1:0]    res_next;

  // Stage 1: operand capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_ADD;
    end else begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op_e'(op_sel);
    end
  end

  alu_mult #(
    .W(DATA_W)
  ) u_mult (
    .a      (a_q),
    .b      (b_q),
    .product(prod)
  );

  assign a_ext    = RES_W'(a_q);
  assign b_ext    = RES_W'(b_q);
  assign prod_ext = RES_W'(prod);

`ifdef ALU_MAC_EN
  logic signed [RES_W-1:0] acc;
  logic signed [RES_W-1:0] acc_next;

  // Accumulator wraps modulo 2^RES_W; only MAC ops touch it.
  assign acc_next = acc + prod_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (op_q == OP_MAC) begin
      acc <= acc_next;
    end
  end
`endif

  always_comb begin
    res_next = '0;
    case (op_q)
      OP_ADD:  res_next = a_ext + b_ext;
      OP_MUL:  res_next = prod_ext;
      OP_SUB:  res_next = a_ext - b_ext;
`ifdef ALU_MAC_EN
      OP_MAC:  res_next = acc_next;
`else
      OP_MAC:  res_next = '0;
`endif
      default: res_next = '0;
    endcase
  end

  // Stage 2: registered result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result <= '0;
    end else begin
      result <= res_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Randomised self-checking bench for alu against a plain-arithmetic reference model.
// Honours ALU_MAC_EN the same way as the design.
module tb_alu;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [1:0]         op_sel = 2'b00;
  logic signed [15:0] a = '0;
  logic signed [15:0] b = '0;
  logic signed [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  int acc_m   = 0;

  logic signed [31:0] exp_d [2];
  string              tag_d [2];

  alu dut (
    .clk   (clk),
    .rst   (rst),
    .op_sel(op_sel),
    .a     (a),
    .b     (b),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic on sign-extended operands; int wraps mod 2^32.
  function automatic logic signed [31:0] model(input logic [1:0] op,
                                               input logic signed [15:0] x,
                                               input logic signed [15:0] y);
    int xi;
    int yi;
    xi = x;
    yi = y;
    case (op)
      2'b00:   return xi + yi;
      2'b01:   return xi * yi;
      2'b10:   return xi - yi;
      default: begin
`ifdef ALU_MAC_EN
        acc_m = acc_m + xi * yi;
        return acc_m;
`else
        return 0;
`endif
      end
    endcase
  endfunction

  // Each call checks the result due from inputs applied two calls earlier.
  task automatic drive(input string tag, input logic [1:0] op,
                       input logic signed [15:0] x, input logic signed [15:0] y);
    @(negedge clk);
    check_eq(tag_d[1], result, exp_d[1]);
    exp_d[1] = exp_d[0];
    tag_d[1] = tag_d[0];
    exp_d[0] = model(op, x, y);
    tag_d[0] = tag;
    op_sel   = op;
    a        = x;
    b        = y;
  endtask

  task automatic reset_hold(input int cycles);
    rst = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_eq("rst_hold", result, 32'sd0);
      op_sel = 2'b01;
      a      = (i % 2 == 0) ? 16'sd5 : 16'sd7;
      b      = (i % 2 == 0) ? 16'sd7 : 16'sd5;
    end
    op_sel = 2'b00;
    a      = '0;
    b      = '0;
    exp_d  = '{32'sd0, 32'sd0};
    tag_d  = '{"post_rst", "post_rst"};
    acc_m  = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [1:0]         rop;
    logic signed [15:0] ra;
    logic signed [15:0] rb;
    logic signed [15:0] extremes [4];
    extremes = '{-16'sd32768, 16'sd32767, 16'sd0, -16'sd1};

    #1 rst = 1'b0;
    #1 check_eq("rst_async_init", result, 32'sd0);
    reset_hold(4);

    drive("add_mixed", 2'b00, 16'sd1000, -16'sd3000);
    drive("add_max",   2'b00, 16'sd32767, 16'sd32767);
    drive("add_min",   2'b00, -16'sd32768, -16'sd32768);
    drive("mul_min",   2'b01, -16'sd32768, -16'sd32768);
    drive("mul_neg",   2'b01, -16'sd300, 16'sd200);
    drive("mul_zero",  2'b01, 16'sd0, 16'sd12345);
    drive("sub_min",   2'b10, -16'sd32768, 16'sd32767);
    drive("b2b_add",   2'b00, 16'sd3, 16'sd4);
    drive("b2b_mul",   2'b01, 16'sd3, 16'sd4);
    drive("b2b_sub",   2'b10, 16'sd3, 16'sd4);
    drive("add_pre",   2'b00, 16'sd1, 16'sd1);
    drive("add_pre2",  2'b00, 16'sd2, 16'sd2);

    // Asynchronous reset mid-cycle: result must clear with no clock edge.
    @(posedge clk);
    #1 check_eq(tag_d[1], result, exp_d[1]);
    #1 rst = 1'b0;
    #1 check_eq("rst_async_mid", result, 32'sd0);
    reset_hold(3);

    for (int i = 0; i < 4; i++) drive("mac_run", 2'b11, 16'sd100, 16'sd50);
    drive("mac_gap_add", 2'b00, 16'sd1, 16'sd2);
    drive("mac_resume",  2'b11, 16'sd100, 16'sd50);
    drive("mac_mul",     2'b01, 16'sd7, -16'sd9);
    drive("mac_resume2", 2'b11, -16'sd100, 16'sd50);

    for (int i = 0; i < 400; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) == 0) ? extremes[$urandom_range(0, 3)] : 16'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? extremes[$urandom_range(0, 3)] : 16'($urandom);
      drive("rand", rop, ra, rb);
    end

    drive("flush", 2'b00, 16'sd0, 16'sd0);
    drive("flush", 2'b00, 16'sd0, 16'sd0);
    drive("flush", 2'b00, 16'sd0, 16'sd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
